// File: rtl/prio_pending_reg.sv
// Sticky pending-request register feeding the 4-input priority encoder.
// Captures request events, masks them onto x_o, and clears bits on serviced acks.
module prio_pending_reg #(
    parameter logic [3:0]  EDGE_MASK = 4'b1111,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_i,
    input  logic [3:0]       mask_i,
    output logic [3:0]       x_o,
    output logic             irq_valid_o,
    input  logic [1:0]       svc_idx_i,
    input  logic             svc_ack_i,
    output logic             ack_err_o,
    output logic [3:0]       ovf_o,
    input  logic             ovf_clr_i,
    output logic [CNT_W-1:0] svc_cnt_o
);

    logic [3:0]       pend_q, pend_d;
    logic [3:0]       req_q;
    logic [3:0]       ovf_q, ovf_d;
    logic             ack_err_q, ack_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       set_ev;
    logic [3:0]       clr_ev;
    logic             ack_hit;

    always_comb begin
        // Level-mode sources ignore the delayed copy, so their set event is the raw line.
        set_ev  = req_i & ~(req_q & EDGE_MASK);
        ack_hit = svc_ack_i & x_o[svc_idx_i];
        clr_ev  = ack_hit ? (4'b0001 << svc_idx_i) : 4'b0000;

        pend_d    = set_ev | (pend_q & ~clr_ev);
        // A new overflow beats a simultaneous clear request.
        ovf_d     = (ovf_q & ~{4{ovf_clr_i}}) | (set_ev & pend_q & ~clr_ev & EDGE_MASK);
        ack_err_d = svc_ack_i & ~x_o[svc_idx_i];

        cnt_d = cnt_q;
        if (ack_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 4'b0000;
            req_q     <= 4'b0000;
            ovf_q     <= 4'b0000;
            ack_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            req_q     <= req_i;
            ovf_q     <= ovf_d;
            ack_err_q <= ack_err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        x_o         = pend_q & ~mask_i;
        irq_valid_o = |x_o;
        ack_err_o   = ack_err_q;
        ovf_o       = ovf_q;
        svc_cnt_o   = cnt_q;
    end

endmodule

// File: tb/tb_prio_pending_reg.sv
// Directed bench for prio_pending_reg: default edge-mode instance plus a
// level-mode, 2-bit-counter instance for re-pend and counter wrap.
module tb_prio_pending_reg;

    logic       clk;
    logic       rst_n;

    logic [3:0] req, mask, x, ovf;
    logic [1:0] idx;
    logic       ack, ovf_clr, irq, ack_err;
    logic [7:0] cnt;

    logic [3:0] req_b, x_b, ovf_b;
    logic [1:0] idx_b;
    logic       ack_b, irq_b, ack_err_b;
    logic [1:0] cnt_b;

    int n_checks;
    int n_fail;

    prio_pending_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .mask_i      (mask),
        .x_o         (x),
        .irq_valid_o (irq),
        .svc_idx_i   (idx),
        .svc_ack_i   (ack),
        .ack_err_o   (ack_err),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
        .svc_cnt_o   (cnt)
    );

    prio_pending_reg #(
        .EDGE_MASK (4'b0000),
        .CNT_W     (2)
    ) dut_lvl (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_b),
        .mask_i      (4'b0000),
        .x_o         (x_b),
        .irq_valid_o (irq_b),
        .svc_idx_i   (idx_b),
        .svc_ack_i   (ack_b),
        .ack_err_o   (ack_err_b),
        .ovf_o       (ovf_b),
        .ovf_clr_i   (1'b0),
        .svc_cnt_o   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at negedge; outputs are observed at the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_ack(input logic [1:0] i);
        idx = i;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        req = 4'b0; mask = 4'b0; idx = 2'd0; ack = 1'b0; ovf_clr = 1'b0;
        req_b = 4'b0; idx_b = 2'd0; ack_b = 1'b0;

        // Reset state
        #12;
        check_eq("rst_x", x, 4'b0000);
        check_eq("rst_irq", irq, 1'b0);
        check_eq("rst_ovf", ovf, 4'b0000);
        check_eq("rst_cnt", cnt, 8'd0);
        check_eq("rst_ackerr", ack_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: pulse 1010, service highest index then the next
        req = 4'b1010;
        tick();
        req = 4'b0000;
        check_eq("t1_x", x, 4'b1010);
        check_eq("t1_irq", irq, 1'b1);
        do_ack(2'd3);
        check_eq("t1_x_after3", x, 4'b0010);
        check_eq("t1_cnt1", cnt, 8'd1);
        do_ack(2'd1);
        check_eq("t1_x_after1", x, 4'b0000);
        check_eq("t1_irq_off", irq, 1'b0);
        check_eq("t1_cnt2", cnt, 8'd2);

        // 2: masked source, bad ack, unmask
        mask = 4'b1000;
        req  = 4'b1001;
        tick();
        req = 4'b0000;
        check_eq("t2_x_masked", x, 4'b0001);
        do_ack(2'd3);
        check_eq("t2_ackerr", ack_err, 1'b1);
        check_eq("t2_x_keep", x, 4'b0001);
        check_eq("t2_cnt_keep", cnt, 8'd2);
        tick();
        check_eq("t2_ackerr_pulse", ack_err, 1'b0);
        mask = 4'b0000;
        #1;
        check_eq("t2_x_unmask", x, 4'b1001);
        @(negedge clk);
        do_ack(2'd0);
        do_ack(2'd3);
        check_eq("t2_x_clean", x, 4'b0000);
        check_eq("t2_cnt4", cnt, 8'd4);

        // 3: second edge on src2 while pending -> overflow, then clear
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        check_eq("t3_ovf", ovf, 4'b0100);
        check_eq("t3_x", x, 4'b0100);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("t3_ovf_clr", ovf, 4'b0000);
        // Clear and new overflow together: overflow wins
        req = 4'b0100;
        ovf_clr = 1'b1;
        tick();
        req = 4'b0000;
        ovf_clr = 1'b0;
        check_eq("t3_ovf_wins", ovf, 4'b0100);
        do_ack(2'd2);
        check_eq("t3_x_clean", x, 4'b0000);
        check_eq("t3_cnt5", cnt, 8'd5);

        // 4: same-cycle edge and ack on src0
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0001;
        do_ack(2'd0);
        req = 4'b0000;
        check_eq("t4_x_set_wins", x, 4'b0001);
        check_eq("t4_cnt6", cnt, 8'd6);
        check_eq("t4_ovf_none", ovf, 4'b0100);

        // 6: fill all sources, then async reset with no clock edge
        tick();
        req = 4'b1111;
        tick();
        req = 4'b0000;
        check_eq("t6_x_full", x, 4'b1111);
        check_eq("t6_ovf_pre", ovf, 4'b0101);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_x", x, 4'b0000);
        check_eq("t6_irq", irq, 1'b0);
        check_eq("t6_ovf", ovf, 4'b0000);
        check_eq("t6_cnt", cnt, 8'd0);
        check_eq("t6_ackerr", ack_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5: level source re-pends under continuous acks; 2-bit counter wraps
        req_b = 4'b0010;
        tick();
        check_eq("t5_x_set", x_b, 4'b0010);
        idx_b = 2'd1;
        ack_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t5_x_repend", x_b, 4'b0010);
        end
        ack_b = 1'b0;
        check_eq("t5_cnt_wrap", cnt_b, 2'd1);
        check_eq("t5_ovf", ovf_b, 4'b0000);
        check_eq("t5_irq", irq_b, 1'b1);
        check_eq("t5_ackerr", ack_err_b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
